// File: rtl/enet_tx_arb.sv
// Frame-atomic two-source arbiter in front of the MAC TX write port, with a beat limit
// that truncates runaway frames. Define ENET_TX_ARB_STATS_EN to get per-source frame counters.
module enet_tx_arb #(
  parameter int MAX_BEATS     = 379,
  parameter bit RR_EN_DEFAULT = 1'b1
) (
  input  logic        wr_clk_i,
  input  logic        wr_rst_i,
  input  logic        enable_i,
  input  logic        rr_mode_i,
  input  logic        s0_valid_i,
  input  logic [31:0] s0_data_i,
  input  logic [3:0]  s0_strb_i,
  input  logic        s0_last_i,
  output logic        s0_accept_o,
  input  logic        s1_valid_i,
  input  logic [31:0] s1_data_i,
  input  logic [3:0]  s1_strb_i,
  input  logic        s1_last_i,
  output logic        s1_accept_o,
  output logic        valid_o,
  output logic [31:0] data_o,
  output logic [3:0]  strb_o,
  output logic        last_o,
  input  logic        accept_i,
  output logic        busy_o,
  output logic        trunc_err_o,
  input  logic        err_clr_i,
  output logic [15:0] s0_frames_o,
  output logic [15:0] s1_frames_o
);

  typedef enum logic [1:0] {IDLE, GRANT, DISCARD} state_t;

  localparam logic [15:0] BEAT_LIM = 16'(MAX_BEATS - 1);

  state_t      state_q, state_d;
  logic        grant_q, grant_d;
  logic        last_grant_q, last_grant_d;
  logic [15:0] beat_cnt_q, beat_cnt_d;
  logic        trunc_q, trunc_d;
  logic        mode_q;

  logic        sel_valid, sel_last, sel_accept, force_last, trunc_set;
  logic [31:0] sel_data;
  logic [3:0]  sel_strb;
  logic        req0, req1;

  assign sel_valid  = grant_q ? s1_valid_i : s0_valid_i;
  assign sel_data   = grant_q ? s1_data_i  : s0_data_i;
  assign sel_strb   = grant_q ? s1_strb_i  : s0_strb_i;
  assign sel_last   = grant_q ? s1_last_i  : s0_last_i;
  assign force_last = (beat_cnt_q == BEAT_LIM);
  assign req0       = enable_i & s0_valid_i;
  assign req1       = enable_i & s1_valid_i;

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    beat_cnt_d   = beat_cnt_q;
    trunc_set    = 1'b0;
    sel_accept   = 1'b0;
    valid_o      = 1'b0;
    data_o       = 32'd0;
    strb_o       = 4'd0;
    last_o       = 1'b0;
    case (state_q)
      IDLE: begin
        if (req0 | req1) begin
          state_d = GRANT;
          if (req0 & req1) grant_d = mode_q ? ~last_grant_q : 1'b0;
          else             grant_d = req1;
        end
      end
      GRANT: begin
        valid_o    = sel_valid;
        data_o     = sel_data;
        strb_o     = sel_strb;
        last_o     = sel_valid & (sel_last | force_last);
        sel_accept = accept_i;
        if (sel_valid & accept_i) begin
          if (sel_last) begin
            state_d      = IDLE;
            last_grant_d = grant_q;
            beat_cnt_d   = 16'd0;
          end else if (force_last) begin
            // Truncated: the rest of the source frame is swallowed in DISCARD
            state_d    = DISCARD;
            trunc_set  = 1'b1;
            beat_cnt_d = 16'd0;
          end else begin
            beat_cnt_d = beat_cnt_q + 16'd1;
          end
        end
      end
      DISCARD: begin
        sel_accept = 1'b1;
        if (sel_valid & sel_last) begin
          state_d      = IDLE;
          last_grant_d = grant_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign trunc_d     = trunc_set ? 1'b1 : (err_clr_i ? 1'b0 : trunc_q);
  assign s0_accept_o = sel_accept & ~grant_q;
  assign s1_accept_o = sel_accept & grant_q;
  assign busy_o      = (state_q != IDLE);
  assign trunc_err_o = trunc_q;

  always_ff @(posedge wr_clk_i) begin
    if (wr_rst_i) begin
      state_q      <= IDLE;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
      beat_cnt_q   <= 16'd0;
      trunc_q      <= 1'b0;
      mode_q       <= RR_EN_DEFAULT;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      beat_cnt_q   <= beat_cnt_d;
      trunc_q      <= trunc_d;
      // Mode only follows the pin while idle so a frame never sees it change
      if (state_q == IDLE) mode_q <= rr_mode_i;
    end
  end

`ifdef ENET_TX_ARB_STATS_EN
  logic        frame_done;
  logic [15:0] s0_frames_q, s1_frames_q;

  assign frame_done = (state_q == GRANT) & sel_valid & accept_i & (sel_last | force_last);

  always_ff @(posedge wr_clk_i) begin
    if (wr_rst_i) begin
      s0_frames_q <= 16'd0;
      s1_frames_q <= 16'd0;
    end else if (frame_done) begin
      if (grant_q) s1_frames_q <= s1_frames_q + 16'd1;
      else         s0_frames_q <= s0_frames_q + 16'd1;
    end
  end

  assign s0_frames_o = s0_frames_q;
  assign s1_frames_o = s1_frames_q;
`else
  assign s0_frames_o = 16'd0;
  assign s1_frames_o = 16'd0;
`endif

endmodule

// File: tb/tb_enet_tx_arb.sv
// Scoreboard bench for enet_tx_arb (MAX_BEATS = 4): expected output beats are queued by the
// directed tests, a monitor branch pops and compares each transfer seen on the MAC side.
module tb_enet_tx_arb;

`ifdef ENET_TX_ARB_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b1;
  logic        rr_mode = 1'b1;
  logic        s0_valid = 1'b0, s1_valid = 1'b0;
  logic [31:0] s0_data = '0, s1_data = '0;
  logic [3:0]  s0_strb = '0, s1_strb = '0;
  logic        s0_last = 1'b0, s1_last = 1'b0;
  logic        s0_accept, s1_accept;
  logic        valid, last, accept = 1'b1, busy, trunc_err, err_clr = 1'b0;
  logic [31:0] data;
  logic [3:0]  strb;
  logic [15:0] s0_frames, s1_frames;

  enet_tx_arb #(.MAX_BEATS(4), .RR_EN_DEFAULT(1'b1)) dut (
    .wr_clk_i(clk), .wr_rst_i(rst), .enable_i(enable), .rr_mode_i(rr_mode),
    .s0_valid_i(s0_valid), .s0_data_i(s0_data), .s0_strb_i(s0_strb), .s0_last_i(s0_last),
    .s0_accept_o(s0_accept),
    .s1_valid_i(s1_valid), .s1_data_i(s1_data), .s1_strb_i(s1_strb), .s1_last_i(s1_last),
    .s1_accept_o(s1_accept),
    .valid_o(valid), .data_o(data), .strb_o(strb), .last_o(last), .accept_i(accept),
    .busy_o(busy), .trunc_err_o(trunc_err), .err_clr_i(err_clr),
    .s0_frames_o(s0_frames), .s1_frames_o(s1_frames)
  );

  always #5 clk = ~clk;

  // {src, last, strb, data}
  logic [37:0] sb[$];
  int errors = 0, checks = 0;
  int cyc = 0, xfer_cnt = 0, first_cyc = 0, last_cyc = 0, disc_cnt = 0;
  bit s1_acc_seen = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [37:0] beat(input bit src, input bit lst, input logic [3:0] st,
                                       input logic [31:0] d);
    return {src, lst, st, d};
  endfunction

  task automatic push_frame(input bit src, input int n, input logic [31:0] base,
                            input logic [3:0] lstrb);
    for (int i = 0; i < n; i++)
      sb.push_back(beat(src, i == n - 1, (i == n - 1) ? lstrb : 4'hF, base + 32'(i)));
  endtask

  // Drives one frame on a source; valid stays asserted afterwards until the caller drops it.
  task automatic send(input bit src, input int n, input logic [31:0] base, input logic [3:0] lstrb);
    bit acc;
    int t;
    for (int i = 0; i < n; i++) begin
      if (src) begin
        s1_valid = 1'b1; s1_data = base + 32'(i); s1_last = (i == n - 1);
        s1_strb = (i == n - 1) ? lstrb : 4'hF;
      end else begin
        s0_valid = 1'b1; s0_data = base + 32'(i); s0_last = (i == n - 1);
        s0_strb = (i == n - 1) ? lstrb : 4'hF;
      end
      acc = 1'b0;
      t = 0;
      while (!acc && t < 200) begin
        @(negedge clk);
        acc = src ? s1_accept : s0_accept;
        @(posedge clk); #1;
        t++;
      end
      if (!acc) begin
        errors++;
        $display("FAIL send_timeout: src %0d beat %0d never accepted", src, i);
        return;
      end
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    s0_valid = 1'b0; s1_valid = 1'b0; s0_last = 1'b0; s1_last = 1'b0;
    accept = 1'b1; err_clr = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    xfer_cnt = 0; disc_cnt = 0; s1_acc_seen = 1'b0;
    @(negedge clk);
    check("rst_valid", valid, 0);
    check("rst_busy", busy, 0);
    check("rst_accept", {s0_accept, s1_accept}, 0);
    check("rst_trunc", trunc_err, 0);
    check("rst_frames", {s0_frames, s1_frames}, 0);
    @(posedge clk); #1;
  endtask

  initial begin
    logic [4:0] pat;
    fork
      forever begin
        @(negedge clk);
        cyc++;
        if (!rst) begin
          if (s1_accept) s1_acc_seen = 1'b1;
          if (busy && !valid && s0_accept) disc_cnt++;
          if (valid && accept) begin
            if (sb.size() == 0) begin
              checks++;
              errors++;
              $display("FAIL sb_unexpected: got beat %0h with nothing expected",
                       {s1_accept, last, strb, data});
            end else begin
              check("sb_beat", {s1_accept, last, strb, data}, sb.pop_front());
            end
            if (xfer_cnt == 0) first_cyc = cyc;
            last_cyc = cyc;
            xfer_cnt++;
          end
        end
      end
    join_none

    // Single source 3-beat frame, grant latency of one cycle
    do_reset();
    push_frame(0, 3, 32'h1111_0000, 4'h3);
    fork
      send(0, 3, 32'h1111_0000, 4'h3);
      begin
        @(negedge clk);
        check("t1_latency_idle", {valid, busy}, 2'b00);
        @(negedge clk);
        check("t1_granted", {valid, s0_accept}, 2'b11);
      end
    join
    s0_valid = 1'b0;
    @(negedge clk);
    check("t1_xfers", xfer_cnt, 3);
    check("t1_idle", busy, 0);
    check("t1_s0_frames", s0_frames, STATS ? 1 : 0);
    check("t1_sb_empty", sb.size(), 0);

    // Round-robin with both sources streaming 2-beat frames
    rr_mode = 1'b1;
    do_reset();
    push_frame(0, 2, 32'hA000_0000, 4'hF);
    push_frame(1, 2, 32'hB000_0000, 4'hF);
    push_frame(0, 2, 32'hA000_0010, 4'hF);
    push_frame(1, 2, 32'hB000_0010, 4'hF);
    fork
      begin send(0, 2, 32'hA000_0000, 4'hF); send(0, 2, 32'hA000_0010, 4'hF); end
      begin send(1, 2, 32'hB000_0000, 4'hF); send(1, 2, 32'hB000_0010, 4'hF); end
    join
    s0_valid = 1'b0; s1_valid = 1'b0;
    @(negedge clk);
    check("t2_xfers", xfer_cnt, 8);
    check("t2_span", last_cyc - first_cyc, 10);
    check("t2_frames", {s0_frames, s1_frames}, STATS ? {16'd2, 16'd2} : 32'd0);
    check("t2_sb_empty", sb.size(), 0);

    // Fixed priority: s1 keeps requesting but never wins while s0 streams
    rr_mode = 1'b0;
    do_reset();
    @(posedge clk); #1;
    push_frame(0, 2, 32'hC000_0000, 4'hF);
    push_frame(0, 2, 32'hC000_0010, 4'hF);
    s1_valid = 1'b1; s1_data = 32'hDEAD_BEEF; s1_strb = 4'hF; s1_last = 1'b1;
    send(0, 2, 32'hC000_0000, 4'hF);
    send(0, 2, 32'hC000_0010, 4'hF);
    s0_valid = 1'b0; s1_valid = 1'b0;
    @(negedge clk);
    check("t3_s1_accept_never", s1_acc_seen, 0);
    check("t3_xfers", xfer_cnt, 4);
    check("t3_frames", {s0_frames, s1_frames}, STATS ? {16'd2, 16'd0} : 32'd0);
    check("t3_sb_empty", sb.size(), 0);
    rr_mode = 1'b1;

    // Truncation of a 6-beat frame at the 4-beat limit, then error clear
    do_reset();
    sb.push_back(beat(0, 0, 4'hF, 32'h5000_0000));
    sb.push_back(beat(0, 0, 4'hF, 32'h5000_0001));
    sb.push_back(beat(0, 0, 4'hF, 32'h5000_0002));
    sb.push_back(beat(0, 1, 4'hF, 32'h5000_0003));
    send(0, 6, 32'h5000_0000, 4'h7);
    s0_valid = 1'b0;
    @(negedge clk);
    check("t4_xfers", xfer_cnt, 4);
    check("t4_discarded", disc_cnt, 2);
    check("t4_trunc_set", trunc_err, 1);
    check("t4_idle", busy, 0);
    check("t4_s0_frames", s0_frames, STATS ? 1 : 0);
    check("t4_sb_empty", sb.size(), 0);
    @(posedge clk); #1 err_clr = 1'b1;
    @(posedge clk); #1 err_clr = 1'b0;
    @(negedge clk);
    check("t4_trunc_clr", trunc_err, 0);

    // Backpressure: accept 1,0,0,1,1 across the granted cycles
    do_reset();
    push_frame(0, 3, 32'h7700_0000, 4'h1);
    pat = 5'b11001;
    fork
      send(0, 3, 32'h7700_0000, 4'h1);
      for (int k = 0; k < 5; k++) begin
        @(posedge clk); #1 accept = pat[k];
        @(negedge clk);
        check("t5_mirror", {s0_accept, s1_accept}, {pat[k], 1'b0});
      end
    join
    s0_valid = 1'b0;
    accept = 1'b1;
    @(negedge clk);
    check("t5_xfers", xfer_cnt, 3);
    check("t5_sb_empty", sb.size(), 0);

    // Reset after the first beat of a frame, then both request: s0 must win
    do_reset();
    sb.push_back(beat(0, 0, 4'hF, 32'h9000_0000));
    s0_valid = 1'b1; s0_data = 32'h9000_0000; s0_strb = 4'hF; s0_last = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    s0_data = 32'h9000_0001;
    rst = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check("t6_rst_valid", valid, 0);
    check("t6_rst_busy", busy, 0);
    check("t6_rst_frames", {s0_frames, s1_frames}, 0);
    check("t6_xfers_before_rst", xfer_cnt, 1);
    @(posedge clk); #1;
    rst = 1'b0;
    s0_data = 32'h9000_0002; s0_last = 1'b1;
    s1_valid = 1'b1; s1_data = 32'h9100_0000; s1_strb = 4'hF; s1_last = 1'b1;
    sb.push_back(beat(0, 1, 4'hF, 32'h9000_0002));
    @(posedge clk); #1;
    @(negedge clk);
    check("t6_first_grant", {s0_accept, s1_accept}, 2'b10);
    @(posedge clk); #1;
    s0_valid = 1'b0; s1_valid = 1'b0;
    @(negedge clk);
    check("t6_sb_empty", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
